// File: rtl/soc_bram_sdp.sv
// Simple-dual-port block RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset clear sequencer.
module soc_bram_sdp #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("soc_bram_sdp: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("soc_bram_sdp: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {StClear, StReady} state_e;

  localparam state_e StReset = (CLEAR_ON_RESET != 0) ? StClear : StReady;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    ready_q, ready_d;
  logic                    clr_we;
  logic                    wr_fire;
  logic                    rd_fire;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  // Clear sequencer: one word per edge, counter wraps to 0 on the final address.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we    = rstn;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
    ready_d = (state_d == StReady);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StReset;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // ready_q is low for the whole clear, so clear and user writes never collide.
  assign wr_fire = rstn & ready_q & wr_en;
  assign rd_fire = rstn & ready_q & rd_en;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Read word, optionally forwarding same-cycle write lanes.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if (RDW_MODE != 0 && wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          rd_word[i*8 +: 8] = wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
    if (READ_LATENCY == 1) begin
      rd_valid_d = rd_fire;
      rd_data_d  = rd_fire ? rd_word : rd_data_q;
    end else begin
      rd_valid_d = s1_valid_q;
      rd_data_d  = s1_valid_q ? s1_data_q : rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_soc_bram_sdp.sv
// Bench for soc_bram_sdp: four clearing instances (latency x RDW mode) plus one
// non-clearing instance, all on shared stimulus, checked against a word-level model.
module tb_soc_bram_sdp;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [3:0]        ready_w;
  logic [3:0]        rd_valid_w;
  logic [3:0][31:0]  rd_data_w;
  logic              ready4;
  logic              rd_valid4;
  logic [31:0]       rd_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance g: READ_LATENCY = 1 + g/2, RDW_MODE = g%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    soc_bram_sdp #(
      .ADDR_WIDTH     (4),
      .DATA_WIDTH     (32),
      .READ_LATENCY   (1 + g / 2),
      .RDW_MODE       (g % 2),
      .CLEAR_ON_RESET (1)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .ready    (ready_w[g]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_be    (wr_be),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_w[g]),
      .rd_valid (rd_valid_w[g])
    );
  end

  soc_bram_sdp #(
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (32),
    .READ_LATENCY   (1),
    .RDW_MODE       (0),
    .CLEAR_ON_RESET (0)
  ) u_dut_noclr (
    .clk      (clk),
    .rstn     (rstn),
    .ready    (ready4),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data4),
    .rd_valid (rd_valid4)
  );

  // Reference model: memory as a plain array, each instance's visible outputs.
  logic [31:0] mmem [16];
  int          clr_left;
  bit          m_ready;
  bit          m_ready4;
  bit          ev4;
  bit          pend_v [4];
  logic [31:0] pend_d [4];
  bit          ev [4];
  logic [31:0] ed [4];

  function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] be, logic [31:0] d);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_edge();
    bit          acc_w, acc_r;
    logic [31:0] old, word;
    if (!rstn) begin
      m_ready  = 1'b0;
      m_ready4 = 1'b0;
      ev4      = 1'b0;
      clr_left = 16;
      for (int i = 0; i < 4; i++) begin
        ev[i] = 1'b0; ed[i] = '0; pend_v[i] = 1'b0; pend_d[i] = '0;
      end
      // Contents are all zero by the time ready rises.
      for (int a = 0; a < 16; a++) mmem[a] = '0;
    end else begin
      acc_w = m_ready && wr_en;
      acc_r = m_ready && rd_en;
      ev4   = m_ready4 && rd_en;
      old   = mmem[rd_addr];
      for (int i = 0; i < 4; i++) begin
        word = old;
        if ((i % 2) == 1 && acc_w && wr_addr == rd_addr) word = merge(old, wr_be, wr_data);
        if (i < 2) begin
          ev[i] = acc_r;
          if (acc_r) ed[i] = word;
        end else begin
          ev[i] = pend_v[i];
          if (pend_v[i]) ed[i] = pend_d[i];
          pend_v[i] = acc_r;
          if (acc_r) pend_d[i] = word;
        end
      end
      if (acc_w) mmem[wr_addr] = merge(mmem[wr_addr], wr_be, wr_data);
      if (!m_ready) begin
        clr_left--;
        if (clr_left == 0) m_ready = 1'b1;
      end
      m_ready4 = 1'b1;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("model_ready[%0d]", i), 32'(ready_w[i]), 32'(m_ready));
      check($sformatf("model_valid[%0d]", i), 32'(rd_valid_w[i]), 32'(ev[i]));
      check($sformatf("model_data[%0d]", i), rd_data_w[i], ed[i]);
    end
    check("model_ready_noclr", 32'(ready4), 32'(m_ready4));
    check("model_valid_noclr", 32'(rd_valid4), 32'(ev4));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic        ev;   // rd_valid expected one edge after this row (latency 1)
    logic [31:0] e0;   // expected data, RDW_MODE=0
    logic [31:0] e1;   // expected data, RDW_MODE=1
  } vec_t;

  vec_t        tv [17];
  bit          prev_ev;
  logic [31:0] prev_e0, prev_e1;

  initial begin
    tv[0]  = '{1'b1, 4'd5, 4'hF, 32'h11223344, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[1]  = '{1'b1, 4'd5, 4'h5, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[2]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd5, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
    tv[3]  = '{1'b1, 4'd7, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[4]  = '{1'b1, 4'd1, 4'hF, 32'hA1A1A1A1, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[5]  = '{1'b1, 4'd2, 4'hF, 32'hB2B2B2B2, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[6]  = '{1'b1, 4'd3, 4'hF, 32'hC3C3C3C3, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[7]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd1, 1'b1, 32'hA1A1A1A1, 32'hA1A1A1A1};
    tv[8]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd2, 1'b1, 32'hB2B2B2B2, 32'hB2B2B2B2};
    tv[9]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd3, 1'b1, 32'hC3C3C3C3, 32'hC3C3C3C3};
    tv[10] = '{1'b1, 4'd7, 4'hF, 32'h01020304, 1'b1, 4'd7, 1'b1, 32'hDEADBEEF, 32'h01020304};
    tv[11] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd7, 1'b1, 32'h01020304, 32'h01020304};
    tv[12] = '{1'b1, 4'd9, 4'h0, 32'hFFFFFFFF, 1'b1, 4'd9, 1'b1, 32'h0, 32'h0};
    tv[13] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd9, 1'b1, 32'h0, 32'h0};
    tv[14] = '{1'b1, 4'd4, 4'h8, 32'hCAFEBABE, 1'b1, 4'd4, 1'b1, 32'h0, 32'hCA000000};
    tv[15] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    tv[16] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h0, 32'h0};

    m_ready = 1'b0; m_ready4 = 1'b0; ev4 = 1'b0; clr_left = 16;
    for (int i = 0; i < 4; i++) begin
      ev[i] = 1'b0; ed[i] = '0; pend_v[i] = 1'b0; pend_d[i] = '0;
    end
    rstn = 1'b0;
    idle();

    // Reset, then clear with requests pending that must be ignored.
    step();
    step();
    check("reset_ready", 32'(ready_w), 32'h0);
    check("reset_valid", 32'(rd_valid_w), 32'h0);
    check("reset_data0", rd_data_w[0], 32'h0);
    rstn = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd6; wr_be = 4'hF; wr_data = 32'hFFFF_FFFF;
    rd_en = 1'b1; rd_addr = 4'd6;
    for (int e = 1; e <= 16; e++) begin
      step();
      check("clear_ready", 32'(ready_w[0]), 32'(e == 16));
      if (e < 16) check("clear_no_valid", 32'(rd_valid_w), 32'h0);
    end
    idle();

    // Every address reads zero after the clear.
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      check("clear_rd_valid", 32'(rd_valid_w[0]), 32'h1);
      check("clear_rd_data", rd_data_w[0], 32'h0);
    end
    idle();
    step();
    step();

    // Directed vectors: lanes, pipelining, read-during-write.
    prev_ev = 1'b0; prev_e0 = '0; prev_e1 = '0;
    for (int k = 0; k < 17; k++) begin
      wr_en = tv[k].we; wr_addr = tv[k].wa; wr_be = tv[k].be; wr_data = tv[k].wd;
      rd_en = tv[k].re; rd_addr = tv[k].ra;
      step();
      check($sformatf("tv%0d_lat1_valid", k), 32'(rd_valid_w[0]), 32'(tv[k].ev));
      check($sformatf("tv%0d_lat2_valid", k), 32'(rd_valid_w[2]), 32'(prev_ev));
      if (tv[k].ev) begin
        check($sformatf("tv%0d_lat1_rdw0", k), rd_data_w[0], tv[k].e0);
        check($sformatf("tv%0d_lat1_rdw1", k), rd_data_w[1], tv[k].e1);
      end
      if (prev_ev) begin
        check($sformatf("tv%0d_lat2_rdw0", k), rd_data_w[2], prev_e0);
        check($sformatf("tv%0d_lat2_rdw1", k), rd_data_w[3], prev_e1);
      end
      prev_ev = tv[k].ev; prev_e0 = tv[k].e0; prev_e1 = tv[k].e1;
    end
    idle();

    // Reset while a latency-2 read is still in flight.
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    idle();
    rstn = 1'b0;
    step();
    check("midrst_valid", 32'(rd_valid_w), 32'h0);
    check("midrst_data3", rd_data_w[3], 32'h0);
    rstn = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      check("reclear_ready", 32'(ready_w[3]), 32'(e == 16));
    end

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rstn    = ($urandom_range(0, 149) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_be   = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      step();
    end
    rstn = 1'b1;
    idle();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
